// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the 802.15.4 receive-frame sequencer.
package rx_frame_pkg;

    localparam int unsigned PHR_LEN_W   = 7;
    localparam logic [7:0]  SFD_DEFAULT = 8'hA7;
    localparam logic [15:0] FCS_POLY    = 16'h1021;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_PREAMBLE,
        ST_SFD,
        ST_PHR,
        ST_PAYLOAD
    } rx_state_e;

    // Bit-reverse a 16-bit word; turns the normal polynomial into its LSB-first form.
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// CDR/FIFO/CPU-side signal bundle for rx_frame_ctrl; o_fcs_ok exists only with RX_FRAME_CTRL_FCS_EN.
interface rx_frame_ctrl_if;
    import rx_frame_pkg::*;

    logic                 i_enable;
    logic                 i_bit;
    logic                 i_bit_valid;
    logic                 i_fifo_full;
    logic                 o_fifo_wr_en;
    logic                 o_fifo_wr_data;
    logic [PHR_LEN_W-1:0] o_frame_len;
    logic                 o_frame_done;
    logic                 o_busy;
    logic                 o_err_overflow;
    logic                 o_err_timeout;
`ifdef RX_FRAME_CTRL_FCS_EN
    logic                 o_fcs_ok;
`endif

    // Driver side: CDR, FIFO flag and CPU status consumer.
    modport master (
        output i_enable, i_bit, i_bit_valid, i_fifo_full,
`ifdef RX_FRAME_CTRL_FCS_EN
        input  o_fcs_ok,
`endif
        input  o_fifo_wr_en, o_fifo_wr_data, o_frame_len, o_frame_done,
        input  o_busy, o_err_overflow, o_err_timeout
    );

    // Sequencer side.
    modport slave (
        input  i_enable, i_bit, i_bit_valid, i_fifo_full,
`ifdef RX_FRAME_CTRL_FCS_EN
        output o_fcs_ok,
`endif
        output o_fifo_wr_en, o_fifo_wr_data, o_frame_len, o_frame_done,
        output o_busy, o_err_overflow, o_err_timeout
    );

endinterface

// File: rtl/crc16_serial.sv
// Serial CRC-16/ITU-T engine, one bit per enable, LSB-first reflected form.
// Only built when RX_FRAME_CTRL_FCS_EN is defined.
`ifdef RX_FRAME_CTRL_FCS_EN
module crc16_serial
    import rx_frame_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        data_i,
    output logic [15:0] crc_c
);
    localparam logic [15:0] POLY_REFL = reflect16(FCS_POLY);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    // crc_c already includes the bit being accepted this cycle.
    always_comb begin
        fb    = crc_q[0] ^ data_i;
        crc_d = (crc_q >> 1) ^ (fb ? POLY_REFL : 16'h0000);
        crc_c = en_i ? crc_d : crc_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            crc_q <= 16'h0000;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

endmodule
`endif

// File: rtl/rx_frame_ctrl.sv
// 802.15.4 receive sequencer: preamble/SFD hunt, PHR capture, PSDU-only FIFO writes.
// RX_FRAME_CTRL_FCS_EN adds the CRC-16 check and the o_fcs_ok status bit.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int unsigned PREAMBLE_BITS  = 32,
    parameter logic [7:0]  SFD_PATTERN    = SFD_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 13
) (
    input logic            i_clk,
    input logic            i_rst,
    rx_frame_ctrl_if.slave bus
);
    localparam int unsigned BIT_CNT_W = 10;
    localparam logic [BIT_CNT_W-1:0] PRE_LAST = BIT_CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] BYTE_LAST = BIT_CNT_W'(7);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rx_state_e            state_q;
    logic [BIT_CNT_W-1:0] cnt_q;
    logic [7:0]           shift_q;
    logic [7:0]           shift_d;
    logic [CNT_W-1:0]     to_q;
    logic [PHR_LEN_W-1:0] len_q;
    logic                 wr_en_q, wr_data_q, done_q, busy_q, ovf_q, to_err_q;
    logic                 wr_c, sfd_hit_c, timer_on_c, to_hit_c;

    // cnt_q is shared: preamble zeros, SFD/PHR bit index (0 in SFD = no '1' seen yet), payload bits left.
    always_comb begin
        shift_d    = {bus.i_bit, shift_q[7:1]};
        wr_c       = bus.i_enable && (state_q == ST_PAYLOAD) && bus.i_bit_valid && !bus.i_fifo_full;
        sfd_hit_c  = bus.i_enable && (state_q == ST_SFD) && bus.i_bit_valid
                     && (cnt_q == BYTE_LAST) && (shift_d == SFD_PATTERN);
        timer_on_c = ((state_q == ST_SFD) && (cnt_q != '0))
                     || (state_q == ST_PHR) || (state_q == ST_PAYLOAD);
        to_hit_c   = timer_on_c && !bus.i_bit_valid && (to_q == TO_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_HUNT;
            cnt_q     <= '0;
            shift_q   <= '0;
            to_q      <= '0;
            len_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            to_err_q <= 1'b0;
            if (!bus.i_enable) begin
                state_q <= ST_HUNT;
                cnt_q   <= '0;
                shift_q <= '0;
                to_q    <= '0;
                busy_q  <= 1'b0;
            end else begin
                // busy lingers one cycle alongside a done/error pulse, then drops in HUNT.
                busy_q <= (state_q == ST_PHR) || (state_q == ST_PAYLOAD);
                to_q   <= (!timer_on_c || bus.i_bit_valid) ? '0 : to_q + CNT_W'(1);
                if (bus.i_bit_valid) begin
                    case (state_q)
                        ST_HUNT: begin
                            if (!bus.i_bit) begin
                                cnt_q   <= BIT_CNT_W'(1);
                                state_q <= ST_PREAMBLE;
                            end
                        end
                        ST_PREAMBLE: begin
                            if (bus.i_bit) begin
                                cnt_q   <= '0;
                                state_q <= ST_HUNT;
                            end else if (cnt_q == PRE_LAST) begin
                                cnt_q   <= '0;
                                state_q <= ST_SFD;
                            end else begin
                                cnt_q <= cnt_q + BIT_CNT_W'(1);
                            end
                        end
                        ST_SFD: begin
                            shift_q <= shift_d;
                            if ((cnt_q != '0) || bus.i_bit) begin
                                if (cnt_q == BYTE_LAST) begin
                                    cnt_q   <= '0;
                                    state_q <= sfd_hit_c ? ST_PHR : ST_HUNT;
                                    busy_q  <= sfd_hit_c;
                                end else begin
                                    cnt_q <= cnt_q + BIT_CNT_W'(1);
                                end
                            end
                        end
                        ST_PHR: begin
                            shift_q <= shift_d;
                            if (cnt_q == BYTE_LAST) begin
                                if (shift_d[PHR_LEN_W-1:0] == '0) begin
                                    cnt_q   <= '0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_HUNT;
                                end else begin
                                    len_q   <= shift_d[PHR_LEN_W-1:0];
                                    cnt_q   <= {shift_d[PHR_LEN_W-1:0], 3'b000};
                                    state_q <= ST_PAYLOAD;
                                end
                            end else begin
                                cnt_q <= cnt_q + BIT_CNT_W'(1);
                            end
                        end
                        ST_PAYLOAD: begin
                            if (bus.i_fifo_full) begin
                                cnt_q   <= '0;
                                ovf_q   <= 1'b1;
                                state_q <= ST_HUNT;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= bus.i_bit;
                                cnt_q     <= cnt_q - BIT_CNT_W'(1);
                                if (cnt_q == BIT_CNT_W'(1)) begin
                                    done_q  <= 1'b1;
                                    state_q <= ST_HUNT;
                                end
                            end
                        end
                        default: state_q <= ST_HUNT;
                    endcase
                end
                if (to_hit_c) begin
                    state_q  <= ST_HUNT;
                    cnt_q    <= '0;
                    to_q     <= '0;
                    to_err_q <= 1'b1;
                end
            end
        end
    end

`ifdef RX_FRAME_CTRL_FCS_EN
    logic [15:0] crc_c;
    logic        fcs_ok_q;

    crc16_serial u_crc (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .clr_i  (sfd_hit_c),
        .en_i   (wr_c),
        .data_i (bus.i_bit),
        .crc_c  (crc_c)
    );

    // Residue is judged on the final PSDU bit so the flag lines up with o_frame_done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fcs_ok_q <= 1'b0;
        end else if (sfd_hit_c) begin
            fcs_ok_q <= 1'b0;
        end else if (wr_c && (cnt_q == BIT_CNT_W'(1))) begin
            fcs_ok_q <= (crc_c == 16'h0000);
        end
    end

    assign bus.o_fcs_ok = fcs_ok_q;
`else
    logic unused_wr_c;
    assign unused_wr_c = wr_c;
`endif

    assign bus.o_fifo_wr_en   = wr_en_q;
    assign bus.o_fifo_wr_data = wr_data_q;
    assign bus.o_frame_len    = len_q;
    assign bus.o_frame_done   = done_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_err_overflow = ovf_q;
    assign bus.o_err_timeout  = to_err_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: frame-level reference model feeds queues, a negedge monitor checks.
module tb_rx_frame_ctrl;
    import rx_frame_pkg::*;

    localparam int          PRE = 32;
    localparam int          TO  = 4096;
    localparam logic [7:0]  SFD = 8'hA7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_frame_ctrl_if bus ();

    rx_frame_ctrl #(
        .PREAMBLE_BITS  (PRE),
        .SFD_PATTERN    (SFD),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (13)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int kind;   // 1 done, 2 overflow, 4 timeout
        int len;
        int wr;
        int fcs;    // -1: not checked
    } ev_t;

    ev_t  exp_ev[$];
    logic exp_wr[$];
    logic pay_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_strobe = 0;
    int to_cyc = -1;
    bit busy_seen = 0;
    int model_len = 0;

    ev_t  m_ev;
    logic m_bit;
    int   m_k;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every observed write/event is popped against the model's queues.
    always @(negedge clk) begin
        if (bus.o_busy) busy_seen = 1'b1;
        if (bus.o_fifo_wr_en) begin
            if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                m_bit = exp_wr.pop_front();
                chk("wr_data", int'(bus.o_fifo_wr_data), int'(m_bit));
            end
        end
        if (bus.o_frame_done || bus.o_err_overflow || bus.o_err_timeout) begin
            m_k = int'(bus.o_frame_done) + 2 * int'(bus.o_err_overflow) + 4 * int'(bus.o_err_timeout);
            if (bus.o_err_timeout) to_cyc = cyc;
            if (exp_ev.size() == 0) chk("unexpected_event", m_k, 0);
            else begin
                m_ev = exp_ev.pop_front();
                chk("event_kind", m_k, m_ev.kind);
                chk("frame_len", int'(bus.o_frame_len), m_ev.len);
                if (m_ev.kind == 1) chk("done_with_write", int'(bus.o_fifo_wr_en), m_ev.wr);
`ifdef RX_FRAME_CTRL_FCS_EN
                if (m_ev.fcs >= 0) chk("fcs_ok", int'(bus.o_fcs_ok), m_ev.fcs);
`endif
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_wr_en"}, int'(bus.o_fifo_wr_en), 0);
        chk({tag, "_wr_data"}, int'(bus.o_fifo_wr_data), 0);
        chk({tag, "_frame_len"}, int'(bus.o_frame_len), 0);
        chk({tag, "_done"}, int'(bus.o_frame_done), 0);
        chk({tag, "_busy"}, int'(bus.o_busy), 0);
        chk({tag, "_ovf"}, int'(bus.o_err_overflow), 0);
        chk({tag, "_timeout"}, int'(bus.o_err_timeout), 0);
`ifdef RX_FRAME_CTRL_FCS_EN
        chk({tag, "_fcs_ok"}, int'(bus.o_fcs_ok), 0);
`endif
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.i_bit = b;
        bus.i_bit_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_bit_valid = 1'b0;
        last_strobe = cyc;
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    task automatic fill_pay(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(logic'($urandom_range(0, 1)));
    endtask

    // Frame-level model, then drive. npay < 0 sends the whole PSDU; rst_abort resets mid-frame.
    task automatic run_frame(input int pre, input logic [7:0] sfd, input logic [7:0] phr,
                             input int full_at, input int gap, input int npay, input bit rst_abort);
        bit          acc, ovf, to_exp;
        int          len, nbits, nsent;
        logic [15:0] crc;
        logic        fb;
        acc    = (pre >= PRE) && (sfd == SFD);
        len    = int'(phr[6:0]);
        nbits  = len * 8;
        nsent  = (npay < 0 || npay > nbits) ? nbits : npay;
        ovf    = 1'b0;
        to_exp = 1'b0;
        busy_seen = 1'b0;
        to_cyc = -1;
        if (acc) begin
            if (len == 0) exp_ev.push_back('{1, model_len, 0, 0});
            else begin
                model_len = len;
                crc = 16'h0000;
                for (int i = 0; i < nsent; i++) begin
                    if (i == full_at) begin
                        exp_ev.push_back('{2, len, 0, -1});
                        ovf = 1'b1;
                        break;
                    end
                    exp_wr.push_back(pay_q[i]);
                    fb  = crc[0] ^ pay_q[i];
                    crc = {1'b0, crc[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
                    if (i == nbits - 1) exp_ev.push_back('{1, len, 1, int'(crc == 16'h0000)});
                end
                if (!ovf && nsent < nbits && !rst_abort) begin
                    exp_ev.push_back('{4, len, 0, -1});
                    to_exp = 1'b1;
                end
            end
        end

        for (int i = 0; i < pre; i++) send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(sfd[i], gap);
        if (acc) begin
            for (int i = 0; i < 8; i++) send_bit(phr[i], gap);
            for (int i = 0; i < nsent; i++) begin
                if (i == full_at) bus.i_fifo_full = 1'b1;
                send_bit(pay_q[i], gap);
                if (i == full_at) break;
            end
            bus.i_fifo_full = 1'b0;
        end

        if (rst_abort) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check_idle("mid_reset");
            model_len = 0;
            rst = 1'b0;
        end
        if (to_exp) begin
            for (int t = 0; t < TO + 50 && to_cyc < 0; t++) begin @(posedge clk); #1; end
            chk("timeout_seen", int'(to_cyc >= 0), 1);
            if (to_cyc >= 0) begin
                chk("timeout_latency", to_cyc - last_strobe, TO);
                chk("busy_after_timeout", int'(bus.o_busy), 0);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_events", exp_ev.size(), 0);
        exp_wr.delete();
        exp_ev.delete();
        chk("busy_seen", int'(busy_seen), int'(acc));
        bus.i_enable = 1'b0;
        @(posedge clk); #1;
        bus.i_enable = 1'b1;
    endtask

    initial begin
        logic [7:0]  sfd_r, phr_r;
        int          len_r, full_r;
        logic [15:0] crc;
        logic        fb;
        rst = 1'b1;
        bus.i_enable = 1'b1;
        bus.i_bit = 1'b0;
        bus.i_bit_valid = 1'b0;
        bus.i_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        fill_pay(24); run_frame(32, SFD, 8'h03, -1, 5, -1, 1'b0);
        run_frame(20, SFD, 8'h03, -1, 5, -1, 1'b0);
        run_frame(32, 8'hA5, 8'h03, -1, 5, -1, 1'b0);
        fill_pay(32); run_frame(32, SFD, 8'h04, 10, 3, -1, 1'b0);
        fill_pay(16); run_frame(34, SFD, 8'h02, -1, 2, -1, 1'b0);
        run_frame(32, SFD, 8'h00, -1, 3, -1, 1'b0);
        run_frame(33, SFD, 8'h80, -1, 1, -1, 1'b0);
        run_frame(32, SFD, 8'h02, -1, 3, 0, 1'b0);
        fill_pay(24); run_frame(32, SFD, 8'h03, -1, 4, 5, 1'b1);
        fill_pay(8);  run_frame(32, SFD, 8'h01, -1, 2, -1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            sfd_r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SFD;
            phr_r  = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
            len_r  = int'(phr_r[6:0]);
            full_r = ($urandom_range(0, 3) == 0 && len_r > 0) ? $urandom_range(0, len_r * 8 - 1) : -1;
            fill_pay(56);
            run_frame($urandom_range(28, 40), sfd_r, phr_r, full_r, $urandom_range(1, 4), -1, 1'b0);
        end

`ifdef RX_FRAME_CTRL_FCS_EN
        fill_pay(24);
        crc = 16'h0000;
        for (int i = 0; i < 24; i++) begin
            fb  = crc[0] ^ pay_q[i];
            crc = {1'b0, crc[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        end
        for (int i = 0; i < 16; i++) pay_q.push_back(crc[i]);
        run_frame(32, SFD, 8'h05, -1, 2, -1, 1'b0);
        pay_q[3] = ~pay_q[3];
        run_frame(32, SFD, 8'h05, -1, 2, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
